// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory arbiter slice.
// Bus widths are taken from def.svh so every block agrees on them.
// No logic here; latency/backpressure not applicable.
package mem_arb_pkg;
`include "def.svh"

    localparam int ADDR_W      = `ADDR_BUS;
    localparam int DATA_W      = `DATA_BUS;
    localparam int NUM_REQ_DEF = 3;
    localparam int RD_LAT_DEF  = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } state_t;
endpackage

// File: rtl/def.svh
// Shared bus widths for the memory subsystem.
// Included by mem_arb_pkg; every consumer picks the widths up from there.
// Change here to retarget address/data bus size for the whole slice.
`ifndef DEF_SVH
`define DEF_SVH
`define ADDR_BUS 32
`define DATA_BUS 32
`endif

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin winner pick: first set request at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; optional MEM_ARB_PRIO_EN gives requester 0 absolute priority.
module rr_picker #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);
    // Scan from ptr upwards (modulo N); first asserted request wins.
    always_comb begin
        logic        found;
        int unsigned k;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
`ifdef MEM_ARB_PRIO_EN
        // Requester 0 pre-empts the rotation; the scan below then only
        // ever lands on the other requesters.
        if (req[0]) begin
            gnt[0] = 1'b1;
            found  = 1'b1;
        end
`endif
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!found && req[k]) begin
                gnt[k] = 1'b1;
                idx    = PW'(k);
                found  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates NUM_REQ requesters onto one memory port (build option MEM_ARB_PRIO_EN: requester 0 always wins).
// Latency: write req->gnt 2 cycles; read req->rvalid RD_LAT+2 cycles; one access in flight at a time.
// Backpressure: requesters hold req/payload until gnt; a request dropped before being latched is ignored.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int RD_LAT  = RD_LAT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*4-1:0]      width_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        rvalid_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      mem_ce_o,
    output logic                      mem_we_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [3:0]                mem_width_o,
    output logic [DATA_W-1:0]         mem_data_o,
    input  logic [DATA_W-1:0]         mem_data_i
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 3;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    win_q, win_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          width_q, width_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                mem_ce_q, mem_ce_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [3:0]          mem_width_q, mem_width_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;

    logic [NUM_REQ-1:0]  req_eff;
    logic [NUM_REQ-1:0]  pick_gnt;
    logic [PTR_W-1:0]    pick_idx;
    logic                req_any;
    logic [PTR_W-1:0]    ptr_nx;

    // A requester whose grant is showing this cycle is still holding req;
    // only a req seen after the grant cycle counts as a fresh request.
    assign req_eff = req_i & ~gnt_q;
    assign req_any = |pick_gnt;

    rr_picker #(.N(NUM_REQ), .PW(PTR_W)) u_picker (
        .req (req_eff),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // Pointer following the current winner; with priority mode requester 0
    // never moves the pointer and the pointer skips slot 0.
    always_comb begin
        ptr_nx = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + PTR_W'(1);
`ifdef MEM_ARB_PRIO_EN
        if (win_q == '0) begin
            ptr_nx = rr_ptr_q;
        end else if (ptr_nx == '0) begin
            ptr_nx = PTR_W'(1);
        end
`endif
    end

    // Next-state logic for the IDLE -> ISSUE -> (RDWAIT) -> IDLE sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_any) state_d = ISSUE;
            ISSUE:   state_d = we_q ? IDLE : RDWAIT;
            RDWAIT:  if (cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch winner in IDLE, drive registered memory command and
    // grant off the ISSUE cycle, capture read data when the countdown expires.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        we_d        = we_q;
        addr_d      = addr_q;
        width_d     = width_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        rvalid_d    = '0;
        rdata_d     = rdata_q;
        mem_ce_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_width_d = mem_width_q;
        mem_data_d  = mem_data_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    win_d   = pick_idx;
                    we_d    = we_i[pick_idx];
                    addr_d  = addr_i[pick_idx*ADDR_W +: ADDR_W];
                    width_d = width_i[pick_idx*4 +: 4];
                    wdata_d = wdata_i[pick_idx*DATA_W +: DATA_W];
                end
            end
            ISSUE: begin
                gnt_d[win_q] = 1'b1;
                mem_ce_d     = 1'b1;
                mem_we_d     = we_q;
                mem_addr_d   = addr_q;
                mem_width_d  = width_q;
                mem_data_d   = wdata_q;
                rr_ptr_d     = ptr_nx;
                cnt_d        = CNT_W'(RD_LAT - 1);
            end
            RDWAIT: begin
                if (cnt_q == '0) begin
                    rdata_d         = mem_data_i;
                    rvalid_d[win_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // State and output registers; synchronous active-low reset aborts any access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            width_q     <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_width_q <= '0;
            mem_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            width_q     <= width_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            mem_ce_q    <= mem_ce_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_width_q <= mem_width_d;
            mem_data_q  <= mem_data_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign mem_ce_o    = mem_ce_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_width_o = mem_width_q;
    assign mem_data_o  = mem_data_q;
endmodule
